// File: rtl/seq_detect_param.sv
// Serial pattern detector with programmable pattern/length, overlap control and flush.
// Optional saturating match counter enabled by defining SEQ_DETECT_MATCH_CNT_EN.
module seq_detect_param #(
   parameter int PAT_W = 8,
   parameter int CNT_W = 16,
   localparam int LW   = $clog2(PAT_W) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   input  logic             din_valid,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LW-1:0]    pat_len,
   input  logic             overlap,
   input  logic             clear,
   output logic             dout,
   output logic [CNT_W-1:0] match_cnt
);

   logic [PAT_W-1:0] r_hist;
   logic [LW-1:0]    r_fill;
   logic             r_dout;

   logic [PAT_W-1:0] w_hist_nxt;
   logic [PAT_W-1:0] w_mask;
   logic [LW-1:0]    w_fill_inc;
   logic             w_len_ok;
   logic             w_match;

   assign w_hist_nxt = {r_hist[PAT_W-2:0], din};
   assign w_fill_inc = (r_fill == LW'(PAT_W)) ? r_fill : r_fill + 1'b1;
   assign w_len_ok   = (pat_len != '0) && (pat_len <= LW'(PAT_W));

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < PAT_W; i++)
         w_mask[i] = (i < int'(pat_len));
   end

   // Only the low pat_len bits of the freshly shifted history take part.
   assign w_match = din_valid && !clear && w_len_ok && (w_fill_inc >= pat_len) &&
                    (((w_hist_nxt ^ pattern) & w_mask) == '0);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_hist <= '0;
         r_fill <= '0;
         r_dout <= 1'b0;
      end else if (clear) begin
         r_hist <= '0;
         r_fill <= '0;
         r_dout <= 1'b0;
      end else if (din_valid) begin
         r_hist <= w_hist_nxt;
         r_fill <= (w_match && !overlap) ? '0 : w_fill_inc;
         r_dout <= w_match;
      end else begin
         r_dout <= 1'b0;
      end
   end

   assign dout = r_dout;

`ifdef SEQ_DETECT_MATCH_CNT_EN
   logic [CNT_W-1:0] r_cnt;

   // Counter ignores clear; only reset returns it to zero.
   always_ff @(posedge clk) begin
      if (!reset)
         r_cnt <= '0;
      else if (w_match && (r_cnt != {CNT_W{1'b1}}))
         r_cnt <= r_cnt + 1'b1;
   end

   assign match_cnt = r_cnt;
`else
   assign match_cnt = '0;
`endif

endmodule
